// File: rtl/tanh_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tanh_arbiter_pkg
// Shared definitions for the tanh engine arbiter: the controller state
// encoding, the operand and result widths of the engine, and the default
// sizing used when the arbiter is instantiated without overrides.
// ---------------------------------------------------------------------------
package tanh_arbiter_pkg;

  // Operand width: 1 integer bit plus 16 fraction bits.
  localparam int X_W   = 17;
  // Engine result width.
  localparam int RES_W = 32;

  // Default number of requesters sharing the engine.
  localparam int DEF_N_REQ   = 4;
  // Default number of WAIT cycles tolerated before an error response.
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a request, grant happens here
    ISSUE = 2'd1,  // eng_start held until the engine drops its old done
    WAIT  = 2'd2,  // waiting for done, bounded by the timeout counter
    RESP  = 2'd3   // one-cycle response pulse to the granted requester
  } state_t;

endpackage : tanh_arbiter_pkg

// File: rtl/tanh_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Starting at index ptr and wrapping from
// N-1 back to 0, returns the first requester whose req bit is set.
//
// Ports:
//   req   in  N      request vector
//   ptr   in  PTR_W  index at which the search starts (highest priority)
//   grant out PTR_W  index of the selected requester (0 when any is 0)
//   any   out 1      at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: every output gets a value before the search loop; a path that
    // leaves grant/any unassigned would infer a latch.
    grant = '0;
    any   = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N; k++) begin
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
      idx = (idx == LAST) ? '0 : idx + PTR_W'(1);
    end
  end

endmodule : rr_pick

// File: rtl/tanh_arbiter.sv
// ---------------------------------------------------------------------------
// tanh_arbiter
// Shares one multi-cycle tanh engine between N_REQ requesters. A request is
// granted round-robin in IDLE, its operand is latched and issued to the
// engine, and the engine result (or a timeout error) is returned to the
// granted requester as a one-cycle response pulse.
//
// Ports:
//   clk         in  1            system clock
//   rst         in  1            asynchronous reset, active high
//   req_valid   in  N_REQ        per-requester request valid
//   req_data    in  X_W*N_REQ    operand x of requester i in [X_W*i +: X_W]
//   req_ready   out N_REQ        one-cycle accept pulse
//   eng_start   out 1            start to the engine
//   eng_x       out X_W          operand to the engine
//   eng_done    in  1            engine done level
//   eng_result  in  RES_W        engine result
//   rsp_valid   out N_REQ        one-cycle response pulse
//   rsp_data    out RES_W        response value, valid with rsp_valid
//   rsp_err     out 1            timeout flag, qualified by rsp_valid
//   busy        out 1            high in every state except IDLE
//
// Timing: grant in IDLE at cycle T; req_ready and eng_start are visible in
// ISSUE at T+1; WAIT starts no earlier than T+2; RESP follows the cycle in
// which done (or the timeout) is seen; IDLE follows RESP.
// TIMEOUT must be at least 1.
// ---------------------------------------------------------------------------
module tanh_arbiter
  import tanh_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [X_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   eng_start,
  output logic [X_W-1:0]         eng_x,
  input  logic                   eng_done,
  input  logic [RES_W-1:0]       eng_result,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [RES_W-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [PTR_W-1:0] LAST    = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant;
  logic [CNT_W-1:0] cnt;

  logic [PTR_W-1:0] pick_grant;
  logic             pick_any;
  logic [PTR_W-1:0] ptr_next;
  logic [CNT_W-1:0] cnt_inc;

  // Operands viewed as an array so the granted one can be selected by index.
  logic [X_W-1:0] req_x [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_x[i] = req_data[X_W*i +: X_W];
  end

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // Priority moves to the requester just after the one granted.
  assign ptr_next = (pick_grant == LAST) ? '0 : pick_grant + PTR_W'(1);

  // The counter saturates at TIMEOUT instead of wrapping back to zero.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below sees the values from before this clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      cnt       <= '0;
      eng_start <= 1'b0;
      eng_x     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Handshake strobes are single-cycle pulses unless re-armed below.
      req_ready <= '0;
      rsp_valid <= '0;

      case (state)
        IDLE: begin
          if (pick_any) begin
            req_ready <= ONE << pick_grant;
            eng_x     <= req_x[pick_grant];
            grant     <= pick_grant;
            ptr       <= ptr_next;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          // A done still high from the previous operation is stale; the
          // engine clears it once it accepts start, so keep start asserted
          // until done reads low.
          if (!eng_done) begin
            eng_start <= 1'b0;
            cnt       <= '0;
            state     <= WAIT;
          end
        end

        WAIT: begin
          cnt <= cnt_inc;
          // done is tested first so that done and the timeout landing in the
          // same cycle still return the real result.
          if (eng_done) begin
            rsp_data  <= eng_result;
            rsp_err   <= 1'b0;
            rsp_valid <= ONE << grant;
            state     <= RESP;
          end else if (cnt_inc == CNT_MAX) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= ONE << grant;
            state     <= RESP;
          end
        end

        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy      <= 1'b0;
          eng_start <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule : tanh_arbiter

// File: tb/tb_tanh_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tanh_arbiter
// Two arbiter instances share clk/rst: instance 0 uses TIMEOUT=64, instance 1
// uses TIMEOUT=8. Each has a small engine model with programmable latency,
// stale-done hold time and result. Stimulus pushes the hand-computed
// response of each transaction into a per-instance queue; a monitor per
// instance compares grants and responses against the queue head.
// Latency is counted from the cycle req_ready is seen to the cycle rsp_valid
// is seen; starts is the number of cycles eng_start is high in ISSUE.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tanh_arbiter;
  import tanh_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int NI = 2;

  typedef struct packed {
    int              who;
    logic [X_W-1:0]  x;
    logic [RES_W-1:0] data;
    logic            err;
    int              lat;
    int              starts;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]     req_valid  [NI];
  logic [X_W*NR-1:0] req_data   [NI];
  logic [NR-1:0]     req_ready  [NI];
  logic              eng_start  [NI];
  logic [X_W-1:0]    eng_x      [NI];
  logic              eng_done   [NI];
  logic [RES_W-1:0]  eng_result [NI];
  logic [NR-1:0]     rsp_valid  [NI];
  logic [RES_W-1:0]  rsp_data   [NI];
  logic              rsp_err    [NI];
  logic              busy       [NI];

  // Engine model knobs per instance; e_lat < 0 means done never rises.
  int               e_lat   [NI];
  int               e_stale [NI];
  logic [RES_W-1:0] e_val   [NI];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push_exp(input int g, input int who, input logic [X_W-1:0] x,
                                   input logic [RES_W-1:0] data, input logic err,
                                   input int lat, input int starts);
    exp_t e;
    e.who = who; e.x = x; e.data = data; e.err = err; e.lat = lat; e.starts = starts;
    if (g == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic int q_size(input int g);
    if (g == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t q_peek(input int g);
    if (g == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic exp_t q_pop(input int g);
    exp_t e;
    if (g == 0) e = q0.pop_front();
    else e = q1.pop_front();
    return e;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    tanh_arbiter #(
      .N_REQ   (NR),
      .TIMEOUT ((g == 0) ? 64 : 8)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_data   (req_data[g]),
      .req_ready  (req_ready[g]),
      .eng_start  (eng_start[g]),
      .eng_x      (eng_x[g]),
      .eng_done   (eng_done[g]),
      .eng_result (eng_result[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_data   (rsp_data[g]),
      .rsp_err    (rsp_err[g]),
      .busy       (busy[g])
    );

    // Engine model: accepts on a rising eng_start, keeps an old done for
    // e_stale cycles (0 = clears it at once), raises done e_lat cycles after
    // acceptance and then holds it until the next start.
    logic             e_done, st_d, e_run;
    int               e_cnt;
    logic [RES_W-1:0] e_res;

    assign eng_done[g]   = e_done;
    assign eng_result[g] = e_res;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        e_done <= 1'b0; st_d <= 1'b0; e_run <= 1'b0; e_cnt <= 0; e_res <= '0;
      end else begin
        st_d <= eng_start[g];
        if (eng_start[g] && !st_d) begin
          e_run <= 1'b1;
          e_cnt <= 0;
          if (e_stale[g] == 0) e_done <= 1'b0;
        end else if (e_run) begin
          e_cnt <= e_cnt + 1;
          if (e_cnt + 1 == e_stale[g]) e_done <= 1'b0;
          if (e_cnt + 1 == e_lat[g]) begin
            e_done <= 1'b1;
            e_res  <= e_val[g];
            e_run  <= 1'b0;
          end
        end
      end
    end

    // Monitor.
    int t_ready  = 0;
    int n_start  = 0;
    bit chk_idle = 1'b0;

    always @(negedge clk) begin
      exp_t e;
      logic [NR-1:0] oh;
      if (!rst) begin
        if (chk_idle) begin
          chk_idle = 1'b0;
          check($sformatf("i%0d busy after response", g), 64'(busy[g]), 64'(0));
        end
        if (req_ready[g] != '0) begin
          if (q_size(g) == 0) begin
            check($sformatf("i%0d unexpected req_ready", g), 64'(req_ready[g]), 64'(0));
          end else begin
            e = q_peek(g);
            oh = '0; oh[e.who[1:0]] = 1'b1;
            check($sformatf("i%0d req_ready", g), 64'(req_ready[g]), 64'(oh));
            check($sformatf("i%0d eng_x at grant", g), 64'(eng_x[g]), 64'(e.x));
            t_ready = cyc;
            n_start = 0;
          end
        end
        if (eng_start[g]) n_start++;
        if (rsp_valid[g] != '0) begin
          if (q_size(g) == 0) begin
            check($sformatf("i%0d unexpected rsp_valid", g), 64'(rsp_valid[g]), 64'(0));
          end else begin
            e = q_pop(g);
            oh = '0; oh[e.who[1:0]] = 1'b1;
            check($sformatf("i%0d rsp_valid", g), 64'(rsp_valid[g]), 64'(oh));
            check($sformatf("i%0d rsp_data", g), 64'(rsp_data[g]), 64'(e.data));
            check($sformatf("i%0d rsp_err", g), 64'(rsp_err[g]), 64'(e.err));
            check($sformatf("i%0d latency", g), 64'(cyc - t_ready), 64'(e.lat));
            check($sformatf("i%0d eng_start cycles", g), 64'(n_start), 64'(e.starts));
            check($sformatf("i%0d eng_x stable", g), 64'(eng_x[g]), 64'(e.x));
            check($sformatf("i%0d busy in resp", g), 64'(busy[g]), 64'(1));
            chk_idle = 1'b1;
          end
        end
      end
    end
  end

  // Raise req_valid, hold it until req_ready is seen, then drop it.
  task automatic request(input int g, input int i, input logic [X_W-1:0] x);
    bit seen = 1'b0;
    req_data[g][X_W*i +: X_W] = x;
    req_valid[g][i] = 1'b1;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (req_ready[g][i]) seen = 1'b1;
    end
    req_valid[g][i] = 1'b0;
    check($sformatf("i%0d req%0d ready seen", g, i), 64'(seen), 64'(1));
  endtask

  task automatic wait_idle(input int g);
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (q_size(g) == 0 && !busy[g]) done = 1'b1;
    end
    check($sformatf("i%0d drained", g), 64'(done), 64'(1));
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < NI; g++) begin
      req_valid[g] = '0; req_data[g] = '0;
      e_lat[g] = 4; e_stale[g] = 0; e_val[g] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All four requesters together from reset: order 0,1,2,3, ptr back to 0.
    e_lat[0] = 4; e_val[0] = 32'h0000_1111;
    push_exp(0, 0, 17'h00100, 32'h0000_1111, 1'b0, 6, 1);
    push_exp(0, 1, 17'h00200, 32'h0000_1111, 1'b0, 6, 2);
    push_exp(0, 2, 17'h00300, 32'h0000_1111, 1'b0, 6, 2);
    push_exp(0, 3, 17'h00400, 32'h0000_1111, 1'b0, 6, 2);
    fork
      request(0, 0, 17'h00100);
      request(0, 1, 17'h00200);
      request(0, 2, 17'h00300);
      request(0, 3, 17'h00400);
    join
    wait_idle(0);
    check("i0 ptr after four grants", 64'(g_inst[0].u_dut.ptr), 64'(0));

    // Single request x=0.5, engine returns 32'h00007666 after 12 cycles.
    e_lat[0] = 12; e_val[0] = 32'h0000_7666;
    push_exp(0, 0, 17'h08000, 32'h0000_7666, 1'b0, 14, 2);
    request(0, 0, 17'h08000);
    wait_idle(0);

    // Stale done held 2 cycles after start is accepted.
    e_lat[0] = 6; e_stale[0] = 2; e_val[0] = 32'h0000_C2F7;
    push_exp(0, 1, 17'h10000, 32'h0000_C2F7, 1'b0, 8, 4);
    request(0, 1, 17'h10000);
    wait_idle(0);
    e_stale[0] = 0;

    // Requesters 3 and 1 with ptr=2: 3 first, then wrap to 1.
    e_lat[0] = 2; e_val[0] = 32'h0000_3333;
    push_exp(0, 3, 17'h04000, 32'h0000_3333, 1'b0, 4, 2);
    push_exp(0, 1, 17'h0C000, 32'h0000_3333, 1'b0, 4, 2);
    fork
      request(0, 3, 17'h04000);
      request(0, 1, 17'h0C000);
    join
    wait_idle(0);

    // Requester 3 raises valid while busy and drops it before IDLE.
    e_lat[0] = 4; e_val[0] = 32'h0000_4444;
    push_exp(0, 0, 17'h02000, 32'h0000_4444, 1'b0, 6, 2);
    fork
      request(0, 0, 17'h02000);
      begin
        repeat (2) @(negedge clk);
        req_valid[0][3] = 1'b1;
        repeat (3) @(negedge clk);
        req_valid[0][3] = 1'b0;
      end
    join
    wait_idle(0);

    // Reset while in WAIT: outputs clear at once, no response.
    e_lat[0] = -1;
    push_exp(0, 0, 17'h1ABCD, 32'h0, 1'b0, 0, 0);
    request(0, 0, 17'h1ABCD);
    repeat (4) @(negedge clk);
    check("i0 busy before reset", 64'(busy[0]), 64'(1));
    rst = 1'b1;
    #1;
    check("reset req_ready", 64'(req_ready[0]), 64'(0));
    check("reset eng_start", 64'(eng_start[0]), 64'(0));
    check("reset eng_x", 64'(eng_x[0]), 64'(0));
    check("reset rsp_valid", 64'(rsp_valid[0]), 64'(0));
    check("reset rsp_data", 64'(rsp_data[0]), 64'(0));
    check("reset rsp_err", 64'(rsp_err[0]), 64'(0));
    check("reset busy", 64'(busy[0]), 64'(0));
    void'(q_pop(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // After reset requester 2 alone is granted.
    e_lat[0] = 3; e_val[0] = 32'h0000_5555;
    push_exp(0, 2, 17'h06000, 32'h0000_5555, 1'b0, 5, 1);
    request(0, 2, 17'h06000);
    wait_idle(0);

    // TIMEOUT=8, engine never finishes: error after 8 WAIT cycles.
    e_lat[1] = -1; e_val[1] = 32'h0000_9999;
    push_exp(1, 0, 17'h01000, 32'h0, 1'b1, 9, 1);
    request(1, 0, 17'h01000);
    wait_idle(1);

    // done arrives in the 8th WAIT cycle: done wins over the timeout.
    e_lat[1] = 7; e_val[1] = 32'h0000_ABCD;
    push_exp(1, 1, 17'h03000, 32'h0000_ABCD, 1'b0, 9, 1);
    request(1, 1, 17'h03000);
    wait_idle(1);

    // done one cycle after the 8th WAIT cycle: timeout error.
    e_lat[1] = 9; e_val[1] = 32'h0000_EEEE;
    push_exp(1, 2, 17'h05000, 32'h0, 1'b1, 10, 2);
    request(1, 2, 17'h05000);
    wait_idle(1);

    repeat (3) @(negedge clk);
    check("i0 scoreboard empty", 64'(q_size(0)), 64'(0));
    check("i1 scoreboard empty", 64'(q_size(1)), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tanh_arbiter

// File: doc/tanh_arbiter.md
TANH_ARBITER -- requirements
Module: tanh_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one tanh engine.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of WAIT cycles before an error response.
REQ-003 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-004 The block SHALL have these ports:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_data  in  17*N_REQ  per-requester operand x; slice i is bits [17i+16:17i]; bit 16 is the integer bit, bits 15:0 are the fraction
- req_ready  out  N_REQ  one-cycle accept pulse per requester
- eng_start  out  1  start to the tanh engine
- eng_x  out  17  operand to the engine
- eng_done  in  1  engine done level
- eng_result  in  32  engine result
- rsp_valid  out  N_REQ  one-cycle response pulse to the granted requester
- rsp_data  out  32  response value, valid while any rsp_valid bit is 1
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- busy  out  1  high in every state except IDLE

Function
REQ-005 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-006 IDLE behaviour:
- If any req_valid is 1, grant the first set bit at or after priority pointer ptr, searching round-robin with wrap from N_REQ-1 to 0.
- In the same cycle: pulse req_ready[grant], latch req_data[grant] into eng_x, store grant, and go to ISSUE.
REQ-007 After each grant, ptr SHALL become (grant+1) mod N_REQ; ptr SHALL NOT change when nothing is granted.
REQ-008 ISSUE behaviour:
- Hold eng_start=1 until eng_done is sampled 0, because the engine clears a stale done when it accepts start.
- Then deassert eng_start and go to WAIT.
- ISSUE lasts at least 1 cycle.
REQ-009 WAIT behaviour:
- When eng_done is sampled 1, capture eng_result into rsp_data, set rsp_err=0, and go to RESP.
REQ-010 WAIT timeout:
- A counter, cleared on entry to WAIT, counts WAIT cycles.
- When it reaches TIMEOUT with eng_done still 0, set rsp_data=0 and rsp_err=1, then go to RESP.
- eng_done and the timeout in the same cycle SHALL resolve to done, not error.
REQ-011 RESP SHALL assert rsp_valid[grant] for exactly one cycle and then return to IDLE; no grant SHALL occur in RESP.
REQ-012 Queued requests behave as follows:
- A requester that keeps req_valid high while the block is busy SHALL be considered in the next IDLE cycle.
- A requester that drops req_valid before it is granted SHALL never be granted or answered.
REQ-013 A requester SHALL hold req_valid and req_data stable until it sees req_ready; the block samples req_data only in the grant cycle.
REQ-014 At most one req_ready bit and at most one rsp_valid bit SHALL be high in any cycle.
REQ-015 Minimum latency SHALL be: grant at cycle T, ISSUE at T+1, WAIT from T+2, response one cycle after done is sampled, IDLE the cycle after the response.
REQ-016 eng_x SHALL stay stable from grant until the block returns to IDLE.
REQ-017 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate rather than wrap.

Reset
REQ-018 On rst=1, independent of clk, the block SHALL go to IDLE and clear ptr, grant, the counter, eng_start, eng_x, req_ready, rsp_valid, rsp_data, rsp_err and busy to 0.
REQ-019 A reset in ISSUE or WAIT SHALL abandon the transaction with no response pulse; the first grant after reset SHALL start the search from requester 0.

Structure
REQ-020 A shared package SHALL hold:
- the state enum
- X_W=17 and RES_W=32
- the default N_REQ and TIMEOUT
REQ-021 The round-robin priority search SHALL be one combinational sub-module, rr_pick, with inputs req and ptr and outputs grant and any.

Verification
REQ-022 Single request: requester 0 sends x=17'h08000 (0.5); the engine model returns 32'h00007666 after 12 cycles.
- Required: req_ready[0] pulses once, eng_start is seen, rsp_valid[0] pulses once with rsp_data=32'h00007666 and rsp_err=0.
REQ-023 All four requesters assert req_valid together from reset.
- Required: grant order is 0,1,2,3, each requester gets exactly one response, and ptr ends at 0.
REQ-024 Stale done: eng_done is held at 1 when start is issued and drops 2 cycles later.
- Required: eng_start stays high for those cycles and no premature response occurs.
REQ-025 Timeout: TIMEOUT=8 and the engine never asserts done.
- Required: rsp_valid pulses after 8 WAIT cycles with rsp_data=0 and rsp_err=1, and the block returns to IDLE.
REQ-026 Reset mid-operation: rst is asserted in WAIT.
- Required: all outputs are 0 immediately, with no rsp_valid.
- After release, requester 2 alone is granted first.
REQ-027 Done at the timeout boundary: eng_done arrives on the same cycle the counter reaches TIMEOUT.
- Required: the response carries eng_result with rsp_err=0.
